// File: rtl/retire_trace_buffer.sv
// Retirement monitor: classifies each retiring instruction, stamps it with
// instruction/cycle numbers and queues it in a first-word-fall-through FIFO.
module retire_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [15:0]   pc,
  input  logic          reg_write,
  input  logic [2:0]    write_reg,
  input  logic [15:0]   write_data,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [15:0]   mem_addr,
  input  logic [15:0]   mem_data,
  input  logic          halt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_type,
  output logic [15:0]   out_inum,
  output logic [15:0]   out_cycle,
  output logic [15:0]   out_pc,
  output logic [2:0]    out_reg,
  output logic [15:0]   out_wdata,
  output logic [15:0]   out_addr,
  output logic [15:0]   out_mdata,
  output logic          overflow,
  output logic [7:0]    drop_count,
  output logic          done,
  output logic [AW:0]   count
);

  localparam logic [2:0] T_NOP  = 3'd0;
  localparam logic [2:0] T_ALU  = 3'd1;
  localparam logic [2:0] T_LD   = 3'd2;
  localparam logic [2:0] T_ST   = 3'd3;
  localparam logic [2:0] T_STU  = 3'd4;
  localparam logic [2:0] T_HALT = 3'd5;

  typedef enum logic [1:0] {S_RUN, S_HALT_PEND, S_HALTED, S_DONE} stateT;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] cycle;
    logic [15:0] pc;
    logic [2:0]  rd;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } recT;

  stateT         stateReg, stateNext;
  logic [15:0]   cycleCtr, inumCtr;
  logic [AW-1:0] headPtr, tailPtr;
  logic [AW:0]   countReg;
  logic          overflowReg;
  logic [7:0]    dropReg;
  recT           pendReg;
  recT           mem [DEPTH];

  recT           newRec, pushRec, headRec;
  logic          capture, full, pop, roomFree, push, dropNow, holdHalt;

  always_comb begin
    newRec       = '0;
    newRec.inum  = inumCtr;
    newRec.cycle = cycleCtr;
    newRec.pc    = pc;
    if (halt) begin
      newRec.kind = T_HALT;
    end else if (reg_write && mem_write) begin
      newRec.kind  = T_STU;
      newRec.rd    = write_reg;
      newRec.wdata = write_data;
      newRec.addr  = mem_addr;
      newRec.mdata = mem_data;
    end else if (reg_write && mem_read) begin
      newRec.kind  = T_LD;
      newRec.rd    = write_reg;
      newRec.wdata = write_data;
      newRec.addr  = mem_addr;
    end else if (reg_write) begin
      newRec.kind  = T_ALU;
      newRec.rd    = write_reg;
      newRec.wdata = write_data;
    end else if (mem_write) begin
      newRec.kind  = T_ST;
      newRec.addr  = mem_addr;
      newRec.mdata = mem_data;
    end else begin
      newRec.kind  = T_NOP;
    end
  end

  assign headRec  = mem[headPtr];
  assign full     = (countReg == (AW+1)'(DEPTH));
  assign pop      = (countReg != '0) && out_ready;
  // A slot freed by this cycle's pop is reusable by this cycle's push.
  assign roomFree = !full || pop;
  assign capture  = en && (stateReg == S_RUN);

  always_comb begin
    stateNext = stateReg;
    pushRec   = newRec;
    push      = 1'b0;
    dropNow   = 1'b0;
    holdHalt  = 1'b0;
    case (stateReg)
      S_RUN: begin
        if (capture) begin
          if (roomFree) begin
            push = 1'b1;
            if (newRec.kind == T_HALT) stateNext = S_HALTED;
          end else if (newRec.kind == T_HALT) begin
            holdHalt  = 1'b1;
            stateNext = S_HALT_PEND;
          end else begin
            dropNow = 1'b1;
          end
        end
      end
      S_HALT_PEND: begin
        pushRec = pendReg;
        if (roomFree) begin
          push      = 1'b1;
          stateNext = S_HALTED;
        end
      end
      S_HALTED: begin
        if (pop && headRec.kind == T_HALT) stateNext = S_DONE;
      end
      default: stateNext = stateReg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= S_RUN;
      cycleCtr    <= '0;
      inumCtr     <= '0;
      headPtr     <= '0;
      tailPtr     <= '0;
      countReg    <= '0;
      overflowReg <= 1'b0;
      dropReg     <= '0;
      pendReg     <= '0;
    end else begin
      stateReg <= stateNext;
      cycleCtr <= cycleCtr + 16'd1;
      if (capture) inumCtr <= inumCtr + 16'd1;
      if (push) tailPtr <= tailPtr + AW'(1);
      if (pop)  headPtr <= headPtr + AW'(1);
      case ({push, pop})
        2'b10:   countReg <= countReg + (AW+1)'(1);
        2'b01:   countReg <= countReg - (AW+1)'(1);
        default: countReg <= countReg;
      endcase
      if (dropNow) begin
        overflowReg <= 1'b1;
        if (dropReg != 8'hFF) dropReg <= dropReg + 8'd1;
      end
      if (holdHalt) pendReg <= newRec;
    end
  end

  // Storage carries no reset; stale entries are hidden by the output gating.
  always_ff @(posedge clk) begin
    if (push) mem[tailPtr] <= pushRec;
  end

  recT outRec;
  assign outRec     = (countReg != '0) ? headRec : '0;
  assign out_valid  = (countReg != '0);
  assign out_type   = outRec.kind;
  assign out_inum   = outRec.inum;
  assign out_cycle  = outRec.cycle;
  assign out_pc     = outRec.pc;
  assign out_reg    = outRec.rd;
  assign out_wdata  = outRec.wdata;
  assign out_addr   = outRec.addr;
  assign out_mdata  = outRec.mdata;
  assign overflow   = overflowReg;
  assign drop_count = dropReg;
  assign done       = (stateReg == S_DONE);
  assign count      = countReg;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: a vector table for single-record
// classification plus hand sequences for overflow, halt and reset corners.
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, reg_write, mem_read, mem_write, halt, out_ready;
  logic [15:0] pc, write_data, mem_addr, mem_data;
  logic [2:0]  write_reg;
  logic        out_valid, overflow, done;
  logic [2:0]  out_type, out_reg;
  logic [15:0] out_inum, out_cycle, out_pc, out_wdata, out_addr, out_mdata;
  logic [7:0]  drop_count;
  logic [3:0]  count;

  int nCmp = 0;
  int nFail = 0;

  retire_trace_buffer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_inum(out_inum), .out_cycle(out_cycle),
    .out_pc(out_pc), .out_reg(out_reg), .out_wdata(out_wdata),
    .out_addr(out_addr), .out_mdata(out_mdata), .overflow(overflow),
    .drop_count(drop_count), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] pc;
    logic        rw;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        mr;
    logic        mw;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic        xValid;
    logic [2:0]  xType;
    logic [15:0] xInum;
    logic [15:0] xCycle;
    logic [15:0] xPc;
    logic [2:0]  xReg;
    logic [15:0] xWdata;
    logic [15:0] xAddr;
    logic [15:0] xMdata;
  } vecT;

  vecT vecs [9];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nCmp++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    en = 0; pc = 0; reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_data = 0; halt = 0;
  endtask

  task automatic setAlu(input logic [15:0] p, input logic [15:0] wd);
    idleInputs();
    en = 1; reg_write = 1; write_reg = 3'd2; write_data = wd; pc = p;
  endtask

  task automatic doReset();
    idleInputs();
    out_ready = 0;
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 16'h0000, 1, 3'd2, 16'h1234, 0, 0, 16'h0000, 16'h0000,
                1, 3'd1, 16'd0, 16'd0, 16'h0000, 3'd2, 16'h1234, 16'h0000, 16'h0000};
    vecs[1] = '{1, 16'h0002, 1, 3'd2, 16'h1234, 0, 0, 16'h0000, 16'h0000,
                1, 3'd1, 16'd1, 16'd1, 16'h0002, 3'd2, 16'h1234, 16'h0000, 16'h0000};
    vecs[2] = '{1, 16'h0004, 1, 3'd2, 16'h1234, 0, 0, 16'h0000, 16'h0000,
                1, 3'd1, 16'd2, 16'd2, 16'h0004, 3'd2, 16'h1234, 16'h0000, 16'h0000};
    vecs[3] = '{1, 16'h0006, 1, 3'd5, 16'h0A0A, 0, 1, 16'h0050, 16'h5555,
                1, 3'd4, 16'd3, 16'd3, 16'h0006, 3'd5, 16'h0A0A, 16'h0050, 16'h5555};
    vecs[4] = '{1, 16'h0008, 1, 3'd3, 16'h7777, 1, 0, 16'h0040, 16'h9999,
                1, 3'd2, 16'd4, 16'd4, 16'h0008, 3'd3, 16'h7777, 16'h0040, 16'h0000};
    vecs[5] = '{1, 16'h000A, 0, 3'd6, 16'h1111, 0, 1, 16'h0042, 16'hBEEF,
                1, 3'd3, 16'd5, 16'd5, 16'h000A, 3'd0, 16'h0000, 16'h0042, 16'hBEEF};
    vecs[6] = '{1, 16'h000C, 0, 3'd1, 16'h2222, 1, 0, 16'h0077, 16'h3333,
                1, 3'd0, 16'd6, 16'd6, 16'h000C, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{0, 16'h000E, 1, 3'd2, 16'h4444, 0, 0, 16'h0000, 16'h0000,
                0, 3'd0, 16'd0, 16'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[8] = '{1, 16'h0010, 1, 3'd7, 16'hCAFE, 0, 0, 16'h0000, 16'h0000,
                1, 3'd1, 16'd7, 16'd8, 16'h0010, 3'd7, 16'hCAFE, 16'h0000, 16'h0000};

    rst = 1;
    idleInputs();
    out_ready = 0;
    #12;
    chk("reset_outputs",
        {out_valid, count, overflow, drop_count, done, out_type, out_inum, out_cycle,
         out_pc, out_reg, out_wdata, out_addr, out_mdata}, '0);
    @(negedge clk) rst = 0;

    // Streaming with the sink always ready: each record appears one cycle after capture.
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      en = vecs[i].en; pc = vecs[i].pc; reg_write = vecs[i].rw;
      write_reg = vecs[i].wreg; write_data = vecs[i].wdata;
      mem_read = vecs[i].mr; mem_write = vecs[i].mw;
      mem_addr = vecs[i].maddr; mem_data = vecs[i].mdata; halt = 0;
      tick();
      chk($sformatf("vec%0d", i),
          {out_valid, out_type, out_inum, out_cycle, out_pc, out_reg, out_wdata, out_addr, out_mdata},
          {vecs[i].xValid, vecs[i].xType, vecs[i].xInum, vecs[i].xCycle, vecs[i].xPc,
           vecs[i].xReg, vecs[i].xWdata, vecs[i].xAddr, vecs[i].xMdata});
    end

    // Overflow: ten captures into eight slots with the sink stalled.
    doReset();
    for (int i = 0; i < 10; i++) begin
      setAlu(16'(2 * i), 16'(16'h0100 + i));
      tick();
    end
    idleInputs();
    chk("ovf_count_flag_drops", {count, overflow, drop_count}, {4'd8, 1'b1, 8'd2});
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovf_drain%0d", i), {out_valid, out_inum, out_wdata},
          {1'b1, 16'(i), 16'(16'h0100 + i)});
      tick();
    end
    out_ready = 0;
    chk("ovf_count_after_3pops", count, 4'd5);

    // Asynchronous reset between clock edges.
    #2 rst = 1;
    #1;
    chk("async_reset_clears", {out_valid, count, overflow, drop_count, done}, '0);
    @(negedge clk) rst = 0;
    setAlu(16'h0200, 16'h5A5A);
    tick();
    chk("post_reset_first", {out_valid, out_inum, out_cycle, out_pc},
        {1'b1, 16'd0, 16'd0, 16'h0200});

    // Push into a full FIFO alongside a pop: nothing dropped.
    doReset();
    for (int i = 0; i < 8; i++) begin
      setAlu(16'(4 * i), 16'(i));
      tick();
    end
    chk("full_before", {count, overflow}, {4'd8, 1'b0});
    setAlu(16'h0300, 16'h0008);
    out_ready = 1;
    tick();
    chk("full_pop_push", {count, overflow, drop_count}, {4'd8, 1'b0, 8'd0});
    idleInputs();
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("full_drain%0d", i), {out_valid, out_inum}, {1'b1, 16'(i)});
      tick();
    end
    chk("full_drained", {out_valid, count}, {1'b0, 4'd0});

    // Halt while full: held, then emitted ninth, then done.
    doReset();
    for (int i = 0; i < 8; i++) begin
      setAlu(16'(2 * i), 16'(i));
      tick();
    end
    idleInputs();
    en = 1; halt = 1; pc = 16'h0100;
    tick();
    chk("halt_pend_held", {count, overflow, drop_count, done}, {4'd8, 1'b0, 8'd0, 1'b0});
    setAlu(16'h0400, 16'hFFFF);
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("halt_drain%0d", i), {out_valid, out_type, out_inum},
          {1'b1, (i < 8) ? 3'd1 : 3'd5, 16'(i)});
      if (i == 8)
        chk("halt_record_fields", {out_cycle, out_pc, out_reg, out_wdata},
            {16'd8, 16'h0100, 3'd0, 16'h0000});
      tick();
    end
    chk("halt_done", {done, out_valid, count}, {1'b1, 1'b0, 4'd0});
    halt = 1;
    tick();
    tick();
    chk("done_sticky_ignores", {done, out_valid, count}, {1'b1, 1'b0, 4'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
